kr580_pic: RTL and testbench

//  Parametrised priority interrupt controller for the KR580 core.
//  - Collects up to CHANNELS external requests and presents one to the CPU's intr pin.
//  - Supplies the matching RST opcode as the vector byte during the interrupt fetch.
//  - Mask, mode, command and status registers are reached through the CPU I/O port bus.
//  - Generalises the single fixed intr line into N prioritised, nestable, maskable channels.

---
 rtl/kr580_pic_if.sv | 25 ++
 rtl/kr580_pic.sv | 145 ++++++++++++++
 tb/tb_kr580_pic.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/kr580_pic_if.sv
// KR580 PIC bus bundle: request lines, CPU I/O port bus,
// and the interrupt request/acknowledge/vector path.
interface kr580_pic_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] irq;
  logic [7:0]          port_a;
  logic [7:0]          port_o;
  logic                port_w;
  logic                port_r;
  logic [7:0]          port_i;
  logic                intr;
  logic                inta;
  logic [7:0]          vector;

  modport master (
    output irq, port_a, port_o, port_w, port_r, inta,
    input  port_i, intr, vector
  );

  modport slave (
    input  irq, port_a, port_o, port_w, port_r, inta,
    output port_i, intr, vector
  );
endinterface

// File: rtl/kr580_pic.sv
// KR580 priority interrupt controller: N nestable maskable
// channels, RST vector supplied during the interrupt fetch.
module kr580_pic #(
  parameter int          CHANNELS  = 8,
  parameter logic [7:0]  BASE_PORT = 8'h20,
  parameter int          RST_BASE  = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  kr580_pic_if.slave   bus
);
  localparam int N  = CHANNELS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] P0 = BASE_PORT;
  localparam logic [7:0] P1 = BASE_PORT + 8'd1;
  localparam logic [7:0] P2 = BASE_PORT + 8'd2;

  typedef enum logic {IDLE, REQ} state_t;

  state_t        r_state, w_next;
  logic [N-1:0]  r_s1, r_s2, r_s3;
  logic [N-1:0]  r_pend, r_mask, r_mode, r_isr;
  logic [IW-1:0] r_idx, w_win;
  logic [7:0]    r_vec, w_vec, w_rd;
  logic [N-1:0]  w_elig, w_eoi_clr, w_ack_set;
  logic [N-1:0]  w_pend_nx, w_isr_nx;
  logic          w_found, w_ack, w_drop;
  logic          w_sel0, w_sel1, w_sel2;
  logic          w_wr0, w_wr1, w_wr2;
  logic          w_eoi, w_clr;

  assign w_sel0 = (bus.port_a == P0);
  assign w_sel1 = (bus.port_a == P1);
  assign w_sel2 = (bus.port_a == P2);
  assign w_wr0  = bus.port_w & w_sel0;
  assign w_wr1  = bus.port_w & w_sel1;
  assign w_wr2  = bus.port_w & w_sel2;
  assign w_eoi  = w_wr1 & bus.port_o[7];
  assign w_clr  = w_wr1 & bus.port_o[6];

  assign w_ack  = (r_state == REQ) & bus.inta;
  assign w_drop = (r_state == REQ) & ~bus.inta &
                  (r_mask[r_idx] | ~r_pend[r_idx]);

  // Fully nested: any in-service bit at or above a channel blocks it
  always_comb begin
    logic acc;
    acc    = 1'b0;
    w_elig = '0;
    for (int n = 0; n < N; n++) begin
      acc       = acc | r_isr[n];
      w_elig[n] = r_pend[n] & ~r_mask[n] & ~acc;
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int n = N - 1; n >= 0; n--) begin
      if (w_elig[n]) begin
        w_found = 1'b1;
        w_win   = IW'(n);
      end
    end
    w_vec = 8'hC7 |
      {2'b00, 3'((RST_BASE + int'(w_win)) & 7), 3'b000};
  end

  always_comb begin
    w_eoi_clr = '0;
    for (int n = N - 1; n >= 0; n--) begin
      if (r_isr[n]) begin
        w_eoi_clr    = '0;
        w_eoi_clr[n] = 1'b1;
      end
    end
    w_ack_set = '0;
    if (w_ack) w_ack_set[r_idx] = 1'b1;
    w_isr_nx = (w_eoi ? (r_isr & ~w_eoi_clr) : r_isr) | w_ack_set;
    // A fresh edge beats any clear in the same cycle
    for (int n = 0; n < N; n++) begin
      if (r_mode[n])
        w_pend_nx[n] = r_s2[n];
      else
        w_pend_nx[n] = (r_s2[n] & ~r_s3[n]) |
          (r_pend[n] & ~(w_clr | w_ack_set[n]));
    end
  end

  always_comb begin
    w_rd = '0;
    if (bus.port_r) begin
      unique case (1'b1)
        w_sel0:  w_rd[N-1:0] = r_mask;
        w_sel1:  w_rd[N-1:0] = r_pend;
        w_sel2:  w_rd[N-1:0] = r_isr;
        default: w_rd = '0;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_found) w_next = REQ;
      REQ:  if (w_ack | w_drop) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_pend <= '0;
      r_isr  <= '0;
      r_mask <= '1;
      r_mode <= '0;
      r_idx  <= '0;
      r_vec  <= 8'hC7;
    end else begin
      r_s1   <= bus.irq;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_pend_nx;
      r_isr  <= w_isr_nx;
      if (w_wr0) r_mask <= bus.port_o[N-1:0];
      if (w_wr2) r_mode <= bus.port_o[N-1:0];
      if (r_state == IDLE && w_found) begin
        r_idx <= w_win;
        r_vec <= w_vec;
      end
    end
  end

  assign bus.port_i = w_rd;
  assign bus.intr   = (r_state == REQ);
  assign bus.vector = r_vec;
endmodule

// File: tb/tb_kr580_pic.sv
// Directed bench for kr580_pic: register table plus
// priority, nesting, withdraw, level-mode and reset sequences.
module tb_kr580_pic;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kr580_pic_if #(.CHANNELS(8)) bus ();

  kr580_pic #(
    .CHANNELS(8),
    .BASE_PORT(8'h20),
    .RST_BASE(0)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.port_a = a;
    bus.port_o = d;
    bus.port_w = 1'b1;
    tick();
    bus.port_w = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [7:0] a,
                    input logic [7:0] e);
    bus.port_a = a;
    bus.port_r = 1'b1;
    #1;
    chk(nm, bus.port_i, e);
    bus.port_r = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    bus.irq = m;
    tick();
    bus.irq = 8'h00;
  endtask

  task automatic ack();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
  endtask

  initial begin
    bus.irq    = '0;
    bus.port_a = '0;
    bus.port_o = '0;
    bus.port_w = 1'b0;
    bus.port_r = 1'b0;
    bus.inta   = 1'b0;

    tbl[0] = '{1'b0, 8'h20, 8'h00, 8'hFF};
    tbl[1] = '{1'b0, 8'h21, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 8'h22, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 8'h20, 8'h3C, 8'h3C};
    tbl[4] = '{1'b1, 8'h20, 8'hA5, 8'hA5};
    tbl[5] = '{1'b1, 8'h22, 8'h00, 8'h00};
    tbl[6] = '{1'b0, 8'h23, 8'h00, 8'h00};
    tbl[7] = '{1'b0, 8'h1F, 8'h00, 8'h00};
    tbl[8] = '{1'b1, 8'h20, 8'hFF, 8'hFF};
    tbl[9] = '{1'b0, 8'h21, 8'h00, 8'h00};

    ticks(3);
    chk("rst_intr", {7'd0, bus.intr}, 8'h00);
    chk("rst_vec", bus.vector, 8'hC7);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
      rd($sformatf("reg%0d", i), tbl[i].a, tbl[i].e);
    end

    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        bus.irq = 8'(i[0] ? 8'hFF : 8'h00);
        tick();
        seen = seen | bus.intr;
      end
      bus.irq = '0;
      ticks(4);
      seen = seen | bus.intr;
      chk("masked_intr", {7'd0, seen}, 8'h00);
    end
    rd("masked_pend", 8'h21, 8'hFF);
    wr(8'h21, 8'h40);
    rd("clr_pend", 8'h21, 8'h00);

    wr(8'h20, 8'hFE);
    pulse(8'h01);
    ticks(2);
    chk("ch0_early", {7'd0, bus.intr}, 8'h00);
    tick();
    chk("ch0_intr", {7'd0, bus.intr}, 8'h01);
    chk("ch0_vec", bus.vector, 8'hC7);
    ack();
    chk("ch0_ackd", {7'd0, bus.intr}, 8'h00);
    rd("ch0_isr", 8'h22, 8'h01);

    wr(8'h20, 8'h00);
    pulse(8'h08);
    ticks(5);
    chk("nest_blk", {7'd0, bus.intr}, 8'h00);
    rd("nest_pend", 8'h21, 8'h08);
    wr(8'h21, 8'h80);
    chk("eoi_gap", {7'd0, bus.intr}, 8'h00);
    tick();
    chk("nest_intr", {7'd0, bus.intr}, 8'h01);
    chk("nest_vec", bus.vector, 8'hDF);
    ack();
    rd("nest_isr", 8'h22, 8'h08);
    wr(8'h21, 8'h80);
    rd("nest_eoi", 8'h22, 8'h00);

    pulse(8'h24);
    ticks(3);
    chk("pri_intr", {7'd0, bus.intr}, 8'h01);
    chk("pri_vec", bus.vector, 8'hD7);
    ack();
    rd("pri_isr", 8'h22, 8'h04);
    tick();
    chk("pri_blk", {7'd0, bus.intr}, 8'h00);
    wr(8'h21, 8'h80);
    tick();
    chk("pri2_intr", {7'd0, bus.intr}, 8'h01);
    chk("pri2_vec", bus.vector, 8'hEF);
    ack();
    wr(8'h21, 8'h80);
    rd("pri_isr0", 8'h22, 8'h00);

    pulse(8'h10);
    ticks(3);
    chk("wd_intr", {7'd0, bus.intr}, 8'h01);
    chk("wd_vec", bus.vector, 8'hE7);
    wr(8'h20, 8'h10);
    chk("wd_hold", {7'd0, bus.intr}, 8'h01);
    tick();
    chk("wd_drop", {7'd0, bus.intr}, 8'h00);
    rd("wd_pend", 8'h21, 8'h10);
    wr(8'h21, 8'h40);
    rd("wd_clr", 8'h21, 8'h00);

    wr(8'h20, 8'h00);
    wr(8'h22, 8'h02);
    bus.irq = 8'h02;
    ticks(4);
    chk("lvl_intr", {7'd0, bus.intr}, 8'h01);
    chk("lvl_vec", bus.vector, 8'hCF);
    ack();
    rd("lvl_isr", 8'h22, 8'h02);
    rd("lvl_pend", 8'h21, 8'h02);
    wr(8'h21, 8'h80);
    tick();
    chk("lvl_rereq", {7'd0, bus.intr}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {7'd0, bus.intr}, 8'h00);
    chk("rst_mvec", bus.vector, 8'hC7);
    bus.irq = '0;
    ticks(2);
    rst_n = 1'b1;
    tick();
    rd("rst_mask", 8'h20, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
